// File: rtl/multicycle_controller.sv
// multicycle_controller
// Main control FSM of the multicycle RISC-V core. Sequences fetch, decode,
// execute, memory and writeback over several clocks and drives the shared
// datapath (single ALU, unified memory port, register file).
//
// Ports:
//   clock_i, reset_n_i        clock (rising edge), async active-low reset
//   opcode_i[6:0]             instruction register bits [6:0], held from DECODE on
//   zero_i                    ALU zero flag (branch decision)
//   mem_ready_i               memory finished the current request this cycle
//   mem_req_o, adr_src_o      memory request, address select (0 PC, 1 ALU)
//   mem_write_o               store strobe
//   IR_write_o, PC_write_o    instruction register / PC load strobes
//   reg_write_o               register file write strobe
//   result_src_o[1:0]         00 ALUOut, 01 data, 10 ALU result
//   ALU_src_a_o[1:0]          00 PC, 01 oldPC, 10 rs1
//   ALU_src_b_o[1:0]          00 rs2, 01 imm, 10 const 4
//   ALU_op_o[1:0]             00 add, 01 sub, 11 decode by funct
//   imm_src_o[1:0]            immediate format, combinational from opcode
//   illegal_o                 sticky illegal-opcode flag
//   retired_o[COUNT_W-1:0]    retired-instruction count (wraps)
module multicycle_controller #(
    parameter int COUNT_W = 32
) (
    input  logic               clock_i,
    input  logic               reset_n_i,
    input  logic [6:0]         opcode_i,
    input  logic               zero_i,
    input  logic               mem_ready_i,
    output logic               mem_req_o,
    output logic               adr_src_o,
    output logic               mem_write_o,
    output logic               IR_write_o,
    output logic               PC_write_o,
    output logic               reg_write_o,
    output logic [1:0]         result_src_o,
    output logic [1:0]         ALU_src_a_o,
    output logic [1:0]         ALU_src_b_o,
    output logic [1:0]         ALU_op_o,
    output logic [1:0]         imm_src_o,
    output logic               illegal_o,
    output logic [COUNT_W-1:0] retired_o
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    typedef enum logic [3:0] {
        S_START, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL, S_HALT
    } state_e;

    state_e             state_q, state_d;
    logic               armed_q, armed_d;
    logic               illegal_q, illegal_d;
    logic [COUNT_W-1:0] retired_q, retired_d;
    logic               retire;

    // START idles one extra cycle after reset release, so the first FETCH
    // lands on the second rising edge; armed_q marks that cycle as spent.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= S_START;
            armed_q   <= 1'b0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            armed_q   <= armed_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        armed_d      = 1'b1;
        retire       = 1'b0;
        mem_req_o    = 1'b0;
        adr_src_o    = 1'b0;
        mem_write_o  = 1'b0;
        IR_write_o   = 1'b0;
        PC_write_o   = 1'b0;
        reg_write_o  = 1'b0;
        result_src_o = 2'b00;
        ALU_src_a_o  = 2'b00;
        ALU_src_b_o  = 2'b00;
        ALU_op_o     = 2'b00;
        unique case (state_q)
            S_START: if (armed_q) state_d = S_FETCH;
            S_FETCH: begin
                mem_req_o    = 1'b1;
                ALU_src_b_o  = 2'b10;
                result_src_o = 2'b10;
                IR_write_o   = mem_ready_i;
                PC_write_o   = mem_ready_i;
                if (mem_ready_i) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALU_src_a_o = 2'b01;
                ALU_src_b_o = 2'b01;
                unique case (opcode_i)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default:      state_d = S_HALT;
                endcase
            end
            S_MEMADR: begin
                ALU_src_a_o = 2'b10;
                ALU_src_b_o = 2'b01;
                state_d     = (opcode_i == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_req_o = 1'b1;
                adr_src_o = 1'b1;
                if (mem_ready_i) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src_o = 2'b01;
                reg_write_o  = 1'b1;
                retire       = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req_o   = 1'b1;
                adr_src_o   = 1'b1;
                mem_write_o = 1'b1;
                if (mem_ready_i) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXECUTER: begin
                ALU_src_a_o = 2'b10;
                ALU_op_o    = 2'b11;
                state_d     = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALU_src_a_o = 2'b10;
                ALU_src_b_o = 2'b01;
                ALU_op_o    = 2'b11;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_o = 1'b1;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end
            S_JAL: begin
                ALU_src_a_o = 2'b01;
                ALU_src_b_o = 2'b10;
                PC_write_o  = 1'b1;
                state_d     = S_ALUWB;
            end
            S_BEQ: begin
                ALU_src_a_o = 2'b10;
                ALU_op_o    = 2'b01;
                PC_write_o  = zero_i;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_START;
        endcase
        illegal_d = illegal_q | (state_d == S_HALT);
        retired_d = retired_q + {{(COUNT_W-1){1'b0}}, retire};
    end

    always_comb begin
        unique case (opcode_i)
            OP_SW:   imm_src_o = 2'b01;
            OP_BEQ:  imm_src_o = 2'b10;
            OP_JAL:  imm_src_o = 2'b11;
            default: imm_src_o = 2'b00;
        endcase
    end

    assign illegal_o = illegal_q;
    assign retired_o = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset_n, zero, mem_ready;
    logic [6:0]    opcode;
    logic          mem_req, adr_src, mem_write, IR_write, PC_write, reg_write, illegal;
    logic [1:0]    result_src, ALU_src_a, ALU_src_b, ALU_op, imm_src;
    logic [CW-1:0] retired;

    always #5 clk = ~clk;

    multicycle_controller #(.COUNT_W(CW)) dut (
        .clock_i(clk), .reset_n_i(reset_n), .opcode_i(opcode), .zero_i(zero),
        .mem_ready_i(mem_ready), .mem_req_o(mem_req), .adr_src_o(adr_src),
        .mem_write_o(mem_write), .IR_write_o(IR_write), .PC_write_o(PC_write),
        .reg_write_o(reg_write), .result_src_o(result_src), .ALU_src_a_o(ALU_src_a),
        .ALU_src_b_o(ALU_src_b), .ALU_op_o(ALU_op), .imm_src_o(imm_src),
        .illegal_o(illegal), .retired_o(retired)
    );

    wire [15:0] all_out = {mem_req, adr_src, mem_write, IR_write, PC_write, reg_write,
                           result_src, ALU_src_a, ALU_src_b, ALU_op};

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: per-instruction totals derived from the instruction rules.
    typedef struct {
        int cyc, irw, regw, pcw, memw;
        bit s11, s01;
        int ret;
    } exp_t;
    exp_t exp_q[$];
    int   ret_model = 0;

    localparam logic [6:0] OPS [6] = '{7'b0110011, 7'b0010011, 7'b0000011,
                                       7'b0100011, 7'b1101111, 7'b1100011};
    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_JAL = 4, K_BEQ = 5;

    function automatic logic [1:0] imm_ref(input logic [6:0] op);
        if (op == 7'b0100011) return 2'b01;
        if (op == 7'b1100011) return 2'b10;
        if (op == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    // Sets inputs for the current cycle, then advances to 1 time unit past the next edge.
    task automatic drive(input logic mr, input logic [6:0] op);
        mem_ready = mr;
        opcode    = op;
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input int k, input int wf, input int wm, input bit z);
        exp_t       e;
        logic [6:0] op;
        op = OPS[k];
        e.cyc  = (k == K_LW) ? 5 + wf + wm : (k == K_SW) ? 4 + wf + wm :
                 (k == K_BEQ) ? 3 + wf : 4 + wf;
        e.irw  = 1;
        e.regw = (k == K_SW || k == K_BEQ) ? 0 : 1;
        e.pcw  = 1 + ((k == K_JAL) ? 1 : 0) + ((k == K_BEQ && z) ? 1 : 0);
        e.memw = (k == K_SW) ? wm + 1 : 0;
        e.s11  = (k == K_R || k == K_I);
        e.s01  = (k == K_BEQ);
        ret_model++;
        e.ret  = ret_model % (1 << CW);
        exp_q.push_back(e);
        zero = z;
        repeat (wf) drive(1'b0, 7'($urandom));
        drive(1'b1, 7'($urandom));
        drive(1'($urandom), op);
        case (k)
            K_LW: begin
                drive(1'($urandom), op);
                repeat (wm) drive(1'b0, op);
                drive(1'b1, op);
                drive(1'($urandom), op);
            end
            K_SW: begin
                drive(1'($urandom), op);
                repeat (wm) drive(1'b0, op);
                drive(1'b1, op);
            end
            K_BEQ: drive(1'($urandom), op);
            default: begin
                drive(1'($urandom), op);
                drive(1'($urandom), op);
            end
        endcase
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1 chk("start_after_edge1", {31'd0, mem_req}, 32'd0);
        @(posedge clk);
        #1 chk("fetch_on_edge2", {30'd0, mem_req, adr_src}, 32'd2);
    endtask

    // Monitor: an instruction window opens on every entry to FETCH.
    bit   mon_en = 0, started = 0, prev_fetch = 0;
    int   w_cyc, w_irw, w_regw, w_pcw, w_memw;
    bit   w_s11, w_s01;

    always @(negedge clk) begin
        if (!mon_en) begin
            started    = 0;
            prev_fetch = 0;
        end else begin
            bit   fetch;
            exp_t e;
            chk("imm_src", {30'd0, imm_src}, {30'd0, imm_ref(opcode)});
            fetch = mem_req && !adr_src;
            if (fetch && !prev_fetch) begin
                if (started) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_instr", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("cycles",     w_cyc,  e.cyc);
                        chk("ir_write",   w_irw,  e.irw);
                        chk("reg_write",  w_regw, e.regw);
                        chk("pc_write",   w_pcw,  e.pcw);
                        chk("mem_write",  w_memw, e.memw);
                        chk("aluop_11",   {31'd0, w_s11}, {31'd0, e.s11});
                        chk("aluop_01",   {31'd0, w_s01}, {31'd0, e.s01});
                        chk("retired",    {28'd0, retired}, e.ret);
                    end
                end
                started = 1;
                w_cyc = 0; w_irw = 0; w_regw = 0; w_pcw = 0; w_memw = 0;
                w_s11 = 0; w_s01 = 0;
            end
            w_cyc++;
            w_irw  += int'(IR_write);
            w_regw += int'(reg_write);
            w_pcw  += int'(PC_write);
            w_memw += int'(mem_write);
            w_s11  |= (ALU_op == 2'b11);
            w_s01  |= (ALU_op == 2'b01);
            prev_fetch = fetch;
        end
    end

    initial begin
        reset_n = 1'b0; mem_ready = 1'b0; opcode = '0; zero = 1'b0;
        #12;
        chk("reset_outputs", {16'd0, all_out}, 32'd0);
        chk("reset_retired", {28'd0, retired}, 32'd0);
        chk("reset_illegal", {31'd0, illegal}, 32'd0);
        release_reset();
        mon_en = 1;

        // Directed: one of each, then waited lw and both beq outcomes.
        run_instr(K_R, 0, 0, 0);
        run_instr(K_I, 0, 0, 0);
        run_instr(K_LW, 0, 0, 0);
        run_instr(K_SW, 0, 0, 0);
        run_instr(K_JAL, 0, 0, 0);
        run_instr(K_BEQ, 0, 0, 0);
        run_instr(K_LW, 3, 2, 0);
        run_instr(K_BEQ, 0, 0, 0);
        run_instr(K_BEQ, 0, 0, 1);
        run_instr(K_SW, 1, 3, 1);
        for (int i = 0; i < 40; i++)
            run_instr($urandom_range(0, 5), $urandom_range(0, 3),
                      $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        repeat (3) drive(1'b0, 7'($urandom));
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        mon_en = 0;

        // Reset while a store waits on memory.
        drive(1'b1, 7'($urandom));
        drive(1'b0, 7'b0100011);
        drive(1'b0, 7'b0100011);
        #2 chk("memwrite_waiting", {31'd0, mem_write}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_outputs", {16'd0, all_out}, 32'd0);
        chk("abort_retired", {28'd0, retired}, 32'd0);
        release_reset();

        // Illegal opcode halts with every strobe low.
        drive(1'b1, 7'($urandom));
        drive(1'b1, 7'b1111111);
        chk("illegal_set", {31'd0, illegal}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            mem_ready = 1'($urandom);
            #2;
            chk("halt_outputs", {15'd0, illegal, all_out}, {15'd0, 1'b1, 16'd0});
            @(posedge clk);
            #1;
        end
        #2 reset_n = 1'b0;
        #1 chk("illegal_cleared", {31'd0, illegal}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
